// File: rtl/valid_ram_flush_pkg.sv
// Shared types and helpers for the valid-tagged RAM with a flush sequencer.
package valid_ram_flush_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_CLEAR = 2'd1;
  localparam state_t ST_DONE  = 2'd2;

  function automatic int unsigned depth_f(input int unsigned addr_bits);
    return 32'd1 << addr_bits;
  endfunction

  // The valid bit sits just above the payload in every stored word.
  function automatic int unsigned vld_idx_f(input int unsigned payload_bits);
    return payload_bits;
  endfunction

endpackage

// File: rtl/ram0.sv
// Simple dual-port synchronous data RAM, read-first, registered read data.
module ram0 #(
  parameter int unsigned DATA_BITS = 32,
  parameter int unsigned ADDR_BITS = 7,
  parameter string       RAM_TYPE  = "block"
) (
  input  logic                 clk,
  input  logic                 wren,
  input  logic [ADDR_BITS-1:0] wraddr,
  input  logic [DATA_BITS-1:0] wrdata,
  input  logic                 rden,
  input  logic [ADDR_BITS-1:0] rdaddr,
  output logic [DATA_BITS-1:0] rddata
);
  import valid_ram_flush_pkg::*;

  localparam int unsigned DEPTH = depth_f(ADDR_BITS);

  logic [DATA_BITS-1:0] rddata_q;

  generate
    if (RAM_TYPE == "distributed") begin : g_dist
      (* ram_style = "distributed" *) logic [DATA_BITS-1:0] mem_q [DEPTH];
      always_ff @(posedge clk) begin
        if (wren) mem_q[wraddr] <= wrdata;
        if (rden) rddata_q <= mem_q[rdaddr];
      end
    end else begin : g_block
      (* ram_style = "block" *) logic [DATA_BITS-1:0] mem_q [DEPTH];
      always_ff @(posedge clk) begin
        if (wren) mem_q[wraddr] <= wrdata;
        if (rden) rddata_q <= mem_q[rdaddr];
      end
    end
  endgenerate

  assign rddata = rddata_q;

endmodule

// File: rtl/valid_ram_flush.sv
// Data RAM with per-entry valid bits, valid-only invalidation port, read port
// with strobe, and a one-entry-per-cycle flush sequencer with write back-pressure.
module valid_ram_flush
  import valid_ram_flush_pkg::*;
#(
  parameter int unsigned PAYLOAD_BITS   = 32,
  parameter int unsigned NUM_ADDR_BITS  = 7,
  parameter string       RAM_TYPE       = "block",
  parameter bit          CLEAR_ON_RESET = 1'b1
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     wea,
  input  logic [NUM_ADDR_BITS-1:0] addra,
  input  logic [PAYLOAD_BITS:0]    dina,
  input  logic                     web,
  input  logic [NUM_ADDR_BITS-1:0] addrb,
  input  logic                     dinb_vld,
  input  logic                     rd_en,
  input  logic [NUM_ADDR_BITS-1:0] rd_addr,
  output logic [PAYLOAD_BITS:0]    dout,
  output logic                     dout_en,
  input  logic                     flush_req,
  output logic                     flush_busy,
  output logic                     flush_done,
  output logic                     wr_ready
);

  localparam int unsigned DEPTH = depth_f(NUM_ADDR_BITS);
  localparam int unsigned VLD   = vld_idx_f(PAYLOAD_BITS);
  localparam logic [NUM_ADDR_BITS-1:0] LAST_ADDR = NUM_ADDR_BITS'(DEPTH - 1);
  localparam state_t RST_STATE = CLEAR_ON_RESET ? ST_CLEAR : ST_IDLE;

  state_t                   state_q, state_d;
  logic [NUM_ADDR_BITS-1:0] cnt_q, cnt_d;
  logic                     busy_q, done_q, wr_ready_q;
  logic                     dout_en_q, dout_vld_q;
  logic [PAYLOAD_BITS-1:0]  rd_data;

  (* ram_style = "distributed" *) logic [DEPTH-1:0] vld_q;

  // Flush sequencer next-state logic
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (flush_req) begin
          state_d = ST_CLEAR;
          cnt_d   = '0;
        end
      end
      ST_CLEAR: begin
        cnt_d = cnt_q + NUM_ADDR_BITS'(1);
        if (cnt_q == LAST_ADDR) state_d = ST_DONE;
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Status flags are registered from the next state so they line up with state_q.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= RST_STATE;
      cnt_q      <= '0;
      busy_q     <= CLEAR_ON_RESET;
      wr_ready_q <= ~CLEAR_ON_RESET;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      busy_q     <= (state_d != ST_IDLE);
      wr_ready_q <= (state_d == ST_IDLE);
      done_q     <= (state_d == ST_DONE);
    end
  end

  // Valid array: flush clear, else port B then port A so port A wins a collision.
  always_ff @(posedge clk) begin
    if (state_q == ST_CLEAR) begin
      vld_q[cnt_q] <= 1'b0;
    end else if (wr_ready_q) begin
      if (web) vld_q[addrb] <= dinb_vld;
      if (wea) vld_q[addra] <= dina[VLD];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      dout_en_q  <= 1'b0;
      dout_vld_q <= 1'b0;
    end else begin
      dout_en_q <= rd_en;
      if (rd_en) dout_vld_q <= vld_q[rd_addr] & ~busy_q;
    end
  end

  ram0 #(
    .DATA_BITS (PAYLOAD_BITS),
    .ADDR_BITS (NUM_ADDR_BITS),
    .RAM_TYPE  (RAM_TYPE)
  ) u_ram0 (
    .clk    (clk),
    .wren   (wea & wr_ready_q),
    .wraddr (addra),
    .wrdata (dina[PAYLOAD_BITS-1:0]),
    .rden   (rd_en),
    .rdaddr (rd_addr),
    .rddata (rd_data)
  );

  assign dout       = {dout_vld_q, rd_data};
  assign dout_en    = dout_en_q;
  assign flush_busy = busy_q;
  assign flush_done = done_q;
  assign wr_ready   = wr_ready_q;

endmodule

// File: tb/tb_valid_ram_flush.sv
// Directed testbench for valid_ram_flush (32-bit payload, 128 entries, flush on reset).
module tb_valid_ram_flush;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        wea, web, dinb_vld, rd_en, flush_req;
  logic [6:0]  addra, addrb, rd_addr;
  logic [32:0] dina;
  logic [32:0] dout;
  logic        dout_en, flush_busy, flush_done, wr_ready;

  int checks = 0;
  int errors = 0;

  valid_ram_flush #(
    .PAYLOAD_BITS   (32),
    .NUM_ADDR_BITS  (7),
    .RAM_TYPE       ("block"),
    .CLEAR_ON_RESET (1'b1)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .wea        (wea),
    .addra      (addra),
    .dina       (dina),
    .web        (web),
    .addrb      (addrb),
    .dinb_vld   (dinb_vld),
    .rd_en      (rd_en),
    .rd_addr    (rd_addr),
    .dout       (dout),
    .dout_en    (dout_en),
    .flush_req  (flush_req),
    .flush_busy (flush_busy),
    .flush_done (flush_done),
    .wr_ready   (wr_ready)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    wea = 1'b0; web = 1'b0; dinb_vld = 1'b0; rd_en = 1'b0; flush_req = 1'b0;
    addra = '0; addrb = '0; rd_addr = '0; dina = '0;
  endtask

  task automatic test_reset();
    int n;
    int dn;
    reset_n = 1'b0;
    idle_inputs();
    tick();
    tick();
    checks++;
    if (dout_en !== 1'b0 || dout[32] !== 1'b0 || flush_done !== 1'b0) begin
      errors++;
      $display("FAIL reset_outs dout_en=%b dout_vld=%b flush_done=%b expected 0 0 0",
               dout_en, dout[32], flush_done);
    end
    checks++;
    if (flush_busy !== 1'b1 || wr_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_busy busy=%b wr_ready=%b expected 1 0", flush_busy, wr_ready);
    end
    reset_n = 1'b1;
    n = 0;
    dn = 0;
    while (flush_busy === 1'b1 && n < 300) begin
      if (flush_done === 1'b1) dn++;
      tick();
      n++;
    end
    checks++;
    if (n != 129) begin
      errors++;
      $display("FAIL reset_flush_len busy_cycles=%0d expected 129", n);
    end
    checks++;
    if (dn != 1 || flush_done !== 1'b0 || wr_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_flush_done pulses=%0d done=%b wr_ready=%b expected 1 0 1",
               dn, flush_done, wr_ready);
    end
    for (int i = 0; i < 128; i++) begin
      rd_en = 1'b1;
      rd_addr = 7'(i);
      tick();
      checks++;
      if (dout_en !== 1'b1 || dout[32] !== 1'b0) begin
        errors++;
        $display("FAIL reset_read_%0d dout_en=%b vld=%b expected 1 0", i, dout_en, dout[32]);
      end
    end
    rd_en = 1'b0;
  endtask

  task automatic test_write();
    wea = 1'b1; addra = 7'd5; dina = {1'b1, 32'hDEADBEEF};
    tick();
    wea = 1'b0;
    rd_en = 1'b1; rd_addr = 7'd5;
    tick();
    rd_en = 1'b0;
    checks++;
    if (dout_en !== 1'b1 || dout !== 33'h1_DEADBEEF) begin
      errors++;
      $display("FAIL write_read dout_en=%b dout=%h expected 1 1deadbeef", dout_en, dout);
    end
    tick();
    checks++;
    if (dout_en !== 1'b0 || dout !== 33'h1_DEADBEEF) begin
      errors++;
      $display("FAIL read_hold dout_en=%b dout=%h expected 0 1deadbeef", dout_en, dout);
    end
  endtask

  task automatic test_collision();
    wea = 1'b1; addra = 7'd9; dina = {1'b1, 32'h12345678};
    web = 1'b1; addrb = 7'd9; dinb_vld = 1'b0;
    tick();
    idle_inputs();
    rd_en = 1'b1; rd_addr = 7'd9;
    tick();
    rd_en = 1'b0;
    checks++;
    if (dout !== 33'h1_12345678) begin
      errors++;
      $display("FAIL collide_same dout=%h expected 112345678", dout);
    end
    wea = 1'b1; addra = 7'd10; dina = {1'b1, 32'h0A0A0A0A};
    tick();
    wea = 1'b1; addra = 7'd9; dina = {1'b1, 32'h00000099};
    web = 1'b1; addrb = 7'd10; dinb_vld = 1'b0;
    tick();
    idle_inputs();
    rd_en = 1'b1; rd_addr = 7'd9;
    tick();
    checks++;
    if (dout !== 33'h1_00000099) begin
      errors++;
      $display("FAIL collide_diff_a dout=%h expected 100000099", dout);
    end
    rd_addr = 7'd10;
    tick();
    rd_en = 1'b0;
    checks++;
    if (dout[32] !== 1'b0) begin
      errors++;
      $display("FAIL collide_diff_b vld=%b expected 0", dout[32]);
    end
    web = 1'b1; addrb = 7'd10; dinb_vld = 1'b1;
    tick();
    idle_inputs();
    rd_en = 1'b1; rd_addr = 7'd10;
    tick();
    rd_en = 1'b0;
    checks++;
    if (dout !== 33'h1_0A0A0A0A) begin
      errors++;
      $display("FAIL portb_revalidate dout=%h expected 10a0a0a0a", dout);
    end
  endtask

  task automatic test_back_to_back();
    rd_en = 1'b1; rd_addr = 7'd5;
    tick();
    checks++;
    if (dout_en !== 1'b1 || dout !== 33'h1_DEADBEEF) begin
      errors++;
      $display("FAIL b2b_5 dout_en=%b dout=%h expected 1 1deadbeef", dout_en, dout);
    end
    rd_addr = 7'd9;
    tick();
    checks++;
    if (dout_en !== 1'b1 || dout !== 33'h1_00000099) begin
      errors++;
      $display("FAIL b2b_9 dout_en=%b dout=%h expected 1 100000099", dout_en, dout);
    end
    rd_addr = 7'd10;
    tick();
    rd_en = 1'b0;
    checks++;
    if (dout_en !== 1'b1 || dout !== 33'h1_0A0A0A0A) begin
      errors++;
      $display("FAIL b2b_10 dout_en=%b dout=%h expected 1 10a0a0a0a", dout_en, dout);
    end
    tick();
    checks++;
    if (dout_en !== 1'b0 || dout !== 33'h1_0A0A0A0A) begin
      errors++;
      $display("FAIL b2b_hold dout_en=%b dout=%h expected 0 10a0a0a0a", dout_en, dout);
    end
  endtask

  task automatic test_read_first();
    wea = 1'b1; addra = 7'd3; dina = {1'b1, 32'h00000001};
    rd_en = 1'b1; rd_addr = 7'd3;
    tick();
    wea = 1'b0;
    checks++;
    if (dout_en !== 1'b1 || dout[32] !== 1'b0) begin
      errors++;
      $display("FAIL read_first_old dout_en=%b vld=%b expected 1 0", dout_en, dout[32]);
    end
    tick();
    rd_en = 1'b0;
    checks++;
    if (dout !== 33'h1_00000001) begin
      errors++;
      $display("FAIL read_first_new dout=%h expected 100000001", dout);
    end
  endtask

  task automatic test_flush_traffic();
    int n;
    bit seen;
    flush_req = 1'b1;
    tick();
    flush_req = 1'b0;
    checks++;
    if (flush_busy !== 1'b1 || wr_ready !== 1'b0) begin
      errors++;
      $display("FAIL flush_start busy=%b wr_ready=%b expected 1 0", flush_busy, wr_ready);
    end
    tick(); tick(); tick();
    wea = 1'b1; addra = 7'd7; dina = {1'b1, 32'h00000077};
    web = 1'b1; addrb = 7'd1; dinb_vld = 1'b1;
    rd_en = 1'b1; rd_addr = 7'd5;
    tick();
    idle_inputs();
    checks++;
    if (dout_en !== 1'b1 || dout[32] !== 1'b0) begin
      errors++;
      $display("FAIL flush_read_masked dout_en=%b vld=%b expected 1 0", dout_en, dout[32]);
    end
    n = 0;
    seen = 1'b0;
    while (!seen && n < 300) begin
      if (flush_done === 1'b1) seen = 1'b1;
      else begin
        tick();
        n++;
      end
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL flush_done_timeout cycles=%0d expected done within 300", n);
    end
    tick();
    checks++;
    if (flush_busy !== 1'b0 || wr_ready !== 1'b1) begin
      errors++;
      $display("FAIL flush_end busy=%b wr_ready=%b expected 0 1", flush_busy, wr_ready);
    end
    rd_en = 1'b1; rd_addr = 7'd7;
    tick();
    checks++;
    if (dout[32] !== 1'b0) begin
      errors++;
      $display("FAIL flush_drop_a vld=%b expected 0", dout[32]);
    end
    rd_addr = 7'd1;
    tick();
    checks++;
    if (dout[32] !== 1'b0) begin
      errors++;
      $display("FAIL flush_drop_b vld=%b expected 0", dout[32]);
    end
    rd_addr = 7'd5;
    tick();
    rd_en = 1'b0;
    checks++;
    if (dout[32] !== 1'b0) begin
      errors++;
      $display("FAIL flush_cleared_5 vld=%b expected 0", dout[32]);
    end
  endtask

  task automatic test_reset_mid_flush();
    int n;
    int dn;
    wea = 1'b1; addra = 7'd100; dina = {1'b1, 32'h00000064};
    tick();
    wea = 1'b0;
    flush_req = 1'b1;
    tick();
    flush_req = 1'b0;
    repeat (60) tick();
    reset_n = 1'b0;
    #1;
    checks++;
    if (flush_busy !== 1'b1 || flush_done !== 1'b0 || dout_en !== 1'b0 || wr_ready !== 1'b0) begin
      errors++;
      $display("FAIL midreset_outs busy=%b done=%b dout_en=%b wr_ready=%b expected 1 0 0 0",
               flush_busy, flush_done, dout_en, wr_ready);
    end
    tick();
    reset_n = 1'b1;
    n = 0;
    dn = 0;
    while (flush_busy === 1'b1 && n < 300) begin
      if (flush_done === 1'b1) dn++;
      flush_req = (n == 10);
      tick();
      n++;
    end
    flush_req = 1'b0;
    checks++;
    if (n != 129 || dn != 1) begin
      errors++;
      $display("FAIL midreset_flush_len busy_cycles=%0d pulses=%0d expected 129 1", n, dn);
    end
    rd_en = 1'b1; rd_addr = 7'd100;
    tick();
    rd_en = 1'b0;
    checks++;
    if (dout_en !== 1'b1 || dout[32] !== 1'b0) begin
      errors++;
      $display("FAIL midreset_cleared dout_en=%b vld=%b expected 1 0", dout_en, dout[32]);
    end
  endtask

  initial begin
    test_reset();
    test_write();
    test_collision();
    test_back_to_back();
    test_read_first();
    test_flush_traffic();
    test_reset_mid_flush();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/valid_ram_flush.md
Name: valid_ram_flush

Overview:
- Successor to the z-culling output-stage single-port-read RAM: a data store with one valid bit per entry. Port A writes data and valid; port B writes valid only, used for invalidation.
- Adds a dedicated read port with a read-enable and a registered read-valid strobe.
- Adds a flush sequencer that invalidates every entry, one address per cycle, on request and optionally after reset.
- Adds a write-ready back-pressure signal while a flush runs.

Parameters:
- PAYLOAD_BITS, 32, width of the data field; stored word is PAYLOAD_BITS+1 with the valid bit at the MSB.
- NUM_ADDR_BITS, 7, address width; DEPTH = 2**NUM_ADDR_BITS.
- RAM_TYPE, "block", ram_style of the data store; valid bits are always distributed.
- CLEAR_ON_RESET, 1, when 1 a flush starts automatically on reset release.

Ports:
- clk  in  1  clock
- reset_n  in  1  asynchronous active-low reset
- wea  in  1  port A write strobe (data + valid)
- addra  in  NUM_ADDR_BITS  port A address
- dina  in  PAYLOAD_BITS+1  port A word; MSB = valid
- web  in  1  port B write strobe (valid only)
- addrb  in  NUM_ADDR_BITS  port B address
- dinb_vld  in  1  valid value written by port B
- rd_en  in  1  read request
- rd_addr  in  NUM_ADDR_BITS  read address
- dout  out  PAYLOAD_BITS+1  read word; MSB = valid
- dout_en  out  1  dout qualifier, 1 cycle after rd_en
- flush_req  in  1  start-flush pulse
- flush_busy  out  1  flush in progress
- flush_done  out  1  one-cycle pulse at flush end
- wr_ready  out  1  = ~flush_busy; writes accepted only when high

Behaviour:
- Reset (reset_n=0, async):
  - dout_en=0, dout valid bit=0, flush_done=0, flush counter=0.
  - State=CLEAR and flush_busy=1 if CLEAR_ON_RESET=1; otherwise IDLE and flush_busy=0.
  - Memory contents are not reset asynchronously.
  - Reset asserted mid-flush restarts the flush at address 0.
- FSM states:
  - IDLE: flush_req=1 -> CLEAR, counter=0.
  - CLEAR: valid[counter] <= 0 each cycle and counter++. When counter==DEPTH-1, clear that entry, then -> DONE.
  - DONE: flush_done=1 for one cycle -> IDLE.
  - flush_req in CLEAR or DONE is ignored.
  - A flush takes exactly DEPTH cycles in CLEAR; flush_busy=1 in CLEAR and DONE.
- Writes (only when wr_ready=1; dropped silently otherwise):
  - wea: data[addra] <= dina[PAYLOAD_BITS-1:0] and valid[addra] <= dina[MSB].
  - web: valid[addrb] <= dinb_vld.
  - wea & web with addra==addrb: port A wins for the valid bit.
  - wea & web with different addresses: both take effect.
- Reads:
  - rd_en at cycle t -> dout and dout_en=1 at t+1; rd_en=0 -> dout_en=0 at t+1, and dout holds its last value.
  - Read-first: a same-cycle write to rd_addr is not visible until the next read.
  - If flush_busy=1 at cycle t, the dout valid bit at t+1 is forced to 0.
  - The data field is undefined when the valid bit is 0; the bench checks it only when valid=1.
- Counter: NUM_ADDR_BITS wide, wraps to 0 on DONE; no overflow state.

Decomposition:
- Shared package:
  - State enum {IDLE, CLEAR, DONE}.
  - DEPTH localparam function.
  - Valid-bit index constant (= PAYLOAD_BITS).
- Data store: instantiate the existing ram0 (wren = wea & wr_ready, rden = rd_en).
- Valid bit array, write arbitration and the flush FSM stay inline; no new sub-module.

Test Plan:
- Use PAYLOAD_BITS=32, NUM_ADDR_BITS=7, CLEAR_ON_RESET=1.
- Reset release: flush_busy=1 for exactly 128 CLEAR cycles plus 1 DONE cycle; flush_done pulses once; then reading addresses 0..127 returns MSB=0.
- Write: wea at addr 5 with dina={1,32'hDEADBEEF}; rd_en at addr 5 next cycle -> dout=33'h1_DEADBEEF with dout_en=1 one cycle later.
- Collision on addr 9: wea with valid 1 and web with dinb_vld=0 in the same cycle -> read of addr 9 gives valid=1. With addra=9 and addrb=10 instead, both writes land.
- Read-first: write addr 3 = {1,32'h1} while reading addr 3 in the same cycle -> old value returned; the next read returns 33'h1_00000001.
- Flush during traffic: flush_req at cycle 0 and wea at addr 7 at cycle 4 -> write dropped (wr_ready=0); reads during flush give MSB=0; after flush_done, addr 7 reads valid=0.
- Reset mid-flush: drop reset_n at counter=60 -> after release, flush restarts at 0 and lasts 128 cycles; flush_req while busy does not extend the flush.
